// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among NUM_REQ requesters; burst lock via SPI_ARB_LOCK_EN.
// Grant/m_start one cycle after req; ack one cycle after m_done or timeout; requesters wait (req level) while master busy.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     lock,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rsp_data,
  output logic                   err,
  output logic [7:0]             m_data_in,
  output logic                   m_start,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [7:0]             m_data_out
);

  localparam int              PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      w_q, w_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         rsp_q, rsp_d;
  logic [7:0]         mdi_q, mdi_d;
  logic               err_q, err_d;
  logic               start_q, start_d;

  logic               rr_found;
  logic [PW-1:0]      rr_win;
  logic               win_vld;
  logic [PW-1:0]      win;

  // First set req bit at or above ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_win   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_win   = PW'(idx);
      end
    end
  end

`ifdef SPI_ARB_LOCK_EN
  logic locked_q, locked_d;

  always_comb begin
    win     = rr_win;
    win_vld = rr_found;
    if (locked_q) begin
      win     = w_q;
      win_vld = req[w_q];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign win         = rr_win;
  assign win_vld     = rr_found;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    w_d       = w_q;
    tmo_cnt_d = tmo_cnt_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    rsp_d     = rsp_q;
    mdi_d     = mdi_q;
    err_d     = err_q;
    start_d   = start_q;
`ifdef SPI_ARB_LOCK_EN
    locked_d  = locked_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef SPI_ARB_LOCK_EN
        // Lock holder went away: release, round-robin resumes next cycle.
        if (locked_q && !req[w_q]) locked_d = 1'b0;
`endif
        if (win_vld && !m_busy) begin
          w_d        = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          mdi_d      = req_data[{win, 3'b000} +: 8];
          start_d    = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        start_d   = 1'b0;
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // m_done has priority over a coinciding timeout.
        if (m_done) begin
          rsp_d   = m_data_out;
          ack_d   = gnt_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_d   = 8'h00;
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      RESP: begin
        ack_d   = '0;
        err_d   = 1'b0;
        gnt_d   = '0;
        ptr_d   = (w_q == LAST_IDX) ? '0 : w_q + 1'b1;
`ifdef SPI_ARB_LOCK_EN
        locked_d = lock[w_q] & ~err_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The master engine is reset from ~reset_n at the top level, so both restart together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      w_q       <= '0;
      tmo_cnt_q <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rsp_q     <= '0;
      mdi_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      w_q       <= w_d;
      tmo_cnt_q <= tmo_cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rsp_q     <= rsp_d;
      mdi_q     <= mdi_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

`ifdef SPI_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) locked_q <= 1'b0;
    else          locked_q <= locked_d;
  end
`endif

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rsp_data  = rsp_q;
  assign err       = err_q;
  assign m_data_in = mdi_q;
  assign m_start   = start_q;

endmodule
